// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// seg_pkg : shared seven-segment code table, FSM states and decode result type
// Revision : 1.0
// ============================================================================
package seg_pkg;

    // Active-low segment patterns g..a, decimal point stripped
    localparam logic [6:0] SEG_CODE_0 = 7'h40;
    localparam logic [6:0] SEG_CODE_1 = 7'h79;
    localparam logic [6:0] SEG_CODE_2 = 7'h24;
    localparam logic [6:0] SEG_CODE_3 = 7'h30;
    localparam logic [6:0] SEG_CODE_4 = 7'h19;
    localparam logic [6:0] SEG_CODE_5 = 7'h12;
    localparam logic [6:0] SEG_CODE_6 = 7'h02;
    localparam logic [6:0] SEG_CODE_7 = 7'h78;
    localparam logic [6:0] SEG_CODE_8 = 7'h00;
    localparam logic [6:0] SEG_CODE_9 = 7'h10;
    localparam logic [6:0] SEG_CODE_A = 7'h08;
    localparam logic [6:0] SEG_CODE_B = 7'h03;
    localparam logic [6:0] SEG_CODE_C = 7'h46;
    localparam logic [6:0] SEG_CODE_D = 7'h21;
    localparam logic [6:0] SEG_CODE_E = 7'h06;
    localparam logic [6:0] SEG_CODE_F = 7'h0E;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOCKED = 2'd2
    } seg_state_e;

    typedef struct packed {
        logic       hit;
        logic       blank;
        logic [3:0] nibble;
    } seg_dec_t;

endpackage
`default_nettype wire

// File: rtl/seg_code_dec.sv
`default_nettype none
// ============================================================================
// seg_code_dec : combinational lookup of a 7-bit segment pattern to a nibble
// Revision : 1.0
// ============================================================================
module seg_code_dec
    import seg_pkg::*;
(
    input  logic [6:0] pat_i,
    output seg_dec_t   dec_o
);

    always_comb begin
        dec_o     = '0;
        dec_o.hit = 1'b1;
        case (pat_i)
            SEG_CODE_0: dec_o.nibble = 4'h0;
            SEG_CODE_1: dec_o.nibble = 4'h1;
            SEG_CODE_2: dec_o.nibble = 4'h2;
            SEG_CODE_3: dec_o.nibble = 4'h3;
            SEG_CODE_4: dec_o.nibble = 4'h4;
            SEG_CODE_5: dec_o.nibble = 4'h5;
            SEG_CODE_6: dec_o.nibble = 4'h6;
            SEG_CODE_7: dec_o.nibble = 4'h7;
            SEG_CODE_8: dec_o.nibble = 4'h8;
            SEG_CODE_9: dec_o.nibble = 4'h9;
            SEG_CODE_A: dec_o.nibble = 4'hA;
            SEG_CODE_B: dec_o.nibble = 4'hB;
            SEG_CODE_C: dec_o.nibble = 4'hC;
            SEG_CODE_D: dec_o.nibble = 4'hD;
            SEG_CODE_E: dec_o.nibble = 4'hE;
            SEG_CODE_F: dec_o.nibble = 4'hF;
            SEG_BLANK: begin
                dec_o.hit   = 1'b0;
                dec_o.blank = 1'b1;
            end
            default:    dec_o.hit = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_bus_decoder.sv
`default_nettype none
// ============================================================================
// seg_bus_decoder : decodes a two-digit multiplexed seven-segment bus to nibbles
// Revision : 1.0
// ============================================================================
module seg_bus_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYC = 16,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs1_n,
    input  logic       cs2_n,
    input  logic [7:0] dx,
    output logic [3:0] dig1_val,
    output logic [3:0] dig2_val,
    output logic       dig1_dp,
    output logic       dig2_dp,
    output logic       dig1_blank,
    output logic       dig2_blank,
    output logic [1:0] dig_vld,
    output logic       upd,
    output logic       err,
    output logic [7:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Bus word {cs1_n, cs2_n, dx}; idle value is all ones
    logic [9:0]       sync1_q;
    logic [9:0]       s_q;
    logic [9:0]       p_q;

    seg_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             commit;
    logic             both_hi;
    logic             changed;

    seg_dec_t         dec;
    logic             known;
    logic             sel1;
    logic             sel2;

    logic [3:0]       val1_q, val1_d, val2_q, val2_d;
    logic             dp1_q, dp1_d, dp2_q, dp2_d;
    logic             bl1_q, bl1_d, bl2_q, bl2_d;
    logic [1:0]       vld_q, vld_d;
    logic             upd_q, upd_d;
    logic             err_q, err_d;
    logic [7:0]       ecnt_q, ecnt_d;

    assign both_hi = s_q[9] & s_q[8];
    assign changed = (s_q != p_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!both_hi) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (changed) begin
                    cnt_d = '0;
                    if (both_hi) state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    commit  = 1'b1;
                    state_d = ST_LOCKED;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LOCKED: begin
                if (changed) begin
                    cnt_d   = '0;
                    state_d = both_hi ? ST_IDLE : ST_SETTLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    seg_code_dec u_dec (
        .pat_i (s_q[6:0]),
        .dec_o (dec)
    );

    assign known = dec.hit | dec.blank;
    assign sel1  = commit & ~s_q[9] & known;
    assign sel2  = commit & ~s_q[8] & known;

    // A blank pattern keeps the last nibble so the value survives a blank-out
    always_comb begin
        val1_d = val1_q;
        val2_d = val2_q;
        dp1_d  = dp1_q;
        dp2_d  = dp2_q;
        bl1_d  = bl1_q;
        bl2_d  = bl2_q;
        vld_d  = vld_q;
        if (sel1) begin
            if (dec.hit) val1_d = dec.nibble;
            bl1_d    = dec.blank;
            dp1_d    = ~s_q[7];
            vld_d[0] = 1'b1;
        end
        if (sel2) begin
            if (dec.hit) val2_d = dec.nibble;
            bl2_d    = dec.blank;
            dp2_d    = ~s_q[7];
            vld_d[1] = 1'b1;
        end
        upd_d  = (val1_d != val1_q) | (val2_d != val2_q) |
                 (dp1_d != dp1_q) | (dp2_d != dp2_q) |
                 (bl1_d != bl1_q) | (bl2_d != bl2_q);
        err_d  = commit & ~known;
        ecnt_d = (err_d && (ecnt_q != 8'hFF)) ? ecnt_q + 8'd1 : ecnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 10'h3FF;
            s_q     <= 10'h3FF;
            p_q     <= 10'h3FF;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            val1_q  <= '0;
            val2_q  <= '0;
            dp1_q   <= 1'b0;
            dp2_q   <= 1'b0;
            bl1_q   <= 1'b0;
            bl2_q   <= 1'b0;
            vld_q   <= '0;
            upd_q   <= 1'b0;
            err_q   <= 1'b0;
            ecnt_q  <= '0;
        end else begin
            sync1_q <= {cs1_n, cs2_n, dx};
            s_q     <= sync1_q;
            p_q     <= s_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            val1_q  <= val1_d;
            val2_q  <= val2_d;
            dp1_q   <= dp1_d;
            dp2_q   <= dp2_d;
            bl1_q   <= bl1_d;
            bl2_q   <= bl2_d;
            vld_q   <= vld_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
            ecnt_q  <= ecnt_d;
        end
    end

    assign dig1_val   = val1_q;
    assign dig2_val   = val2_q;
    assign dig1_dp    = dp1_q;
    assign dig2_dp    = dp2_q;
    assign dig1_blank = bl1_q;
    assign dig2_blank = bl2_q;
    assign dig_vld    = vld_q;
    assign upd        = upd_q;
    assign err        = err_q;
    assign err_cnt    = ecnt_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_bus_decoder.sv
`default_nettype none
// ============================================================================
// tb_seg_bus_decoder : directed stimulus with a queued expected-event scoreboard
// Revision : 1.0
// ============================================================================
module tb_seg_bus_decoder;

    typedef struct {
        logic [23:0] v;
        int          lo;
        int          hi;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       cs1_n;
    logic       cs2_n;
    logic [7:0] dx;
    logic [3:0] dig1_val, dig2_val;
    logic       dig1_dp, dig2_dp, dig1_blank, dig2_blank;
    logic [1:0] dig_vld;
    logic       upd, err;
    logic [7:0] err_cnt;

    int   total;
    int   bad;
    int   cyc;
    exp_t exp_q[$];
    logic [23:0] act;

    seg_bus_decoder #(.STABLE_CYC(16), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs1_n      (cs1_n),
        .cs2_n      (cs2_n),
        .dx         (dx),
        .dig1_val   (dig1_val),
        .dig2_val   (dig2_val),
        .dig1_dp    (dig1_dp),
        .dig2_dp    (dig2_dp),
        .dig1_blank (dig1_blank),
        .dig2_blank (dig2_blank),
        .dig_vld    (dig_vld),
        .upd        (upd),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    assign act = {upd, err, dig1_val, dig2_val, dig1_dp, dig2_dp,
                  dig1_blank, dig2_blank, dig_vld, err_cnt};

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic drive(input logic c1, input logic c2, input logic [7:0] d);
        cs1_n = c1;
        cs2_n = c2;
        dx    = d;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input logic u, input logic e, input logic [3:0] v1,
                        input logic [3:0] v2, input logic dp1, input logic dp2,
                        input logic b1, input logic b2, input logic [1:0] vl,
                        input logic [7:0] ec, input int lo, input int hi);
        exp_t x;
        x.v  = {u, e, v1, v2, dp1, dp2, b1, b2, vl, ec};
        x.lo = lo;
        x.hi = hi;
        exp_q.push_back(x);
    endtask

    task automatic check(input string name, input logic [23:0] got, input logic [23:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    // Monitor: every upd/err pulse must match the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && (upd === 1'b1 || err === 1'b1)) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event: got %h at cycle %0d required no event", act, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e.v || (e.lo >= 0 && (cyc < e.lo || cyc > e.hi))) begin
                        bad++;
                        $display("FAIL event: got %h at cycle %0d required %h in cycles %0d..%0d",
                                 act, cyc, e.v, e.lo, e.hi);
                    end
                end
            end
        end
    end

    initial begin
        int c;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 8'hFF);
        wait_cyc(3);
        check("reset_state", act, 24'h0);
        rst_n = 1'b1;
        wait_cyc(3);

        // Digit 1 shows "2", dp off
        drive(1'b0, 1'b1, 8'hA4);
        push(1, 0, 4'h2, 4'h0, 0, 0, 0, 0, 2'b01, 8'd0, -1, -1);
        wait_cyc(40);
        check("dig2_untouched", {20'h0, dig2_val, dig2_dp, dig2_blank}, 24'h0);

        // Both digits "F" with dp
        drive(1'b0, 1'b0, 8'h0E);
        push(1, 0, 4'hF, 4'hF, 1, 1, 0, 0, 2'b11, 8'd0, -1, -1);
        wait_cyc(40);

        // Toggling faster than the stability window never commits
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, (i % 2 == 0) ? 8'hC0 : 8'hF9);
            wait_cyc(5);
        end
        drive(1'b0, 1'b1, 8'hF9);
        c = cyc;
        push(1, 0, 4'h1, 4'hF, 0, 1, 0, 0, 2'b11, 8'd0, c + 18, c + 20);
        wait_cyc(40);

        // Blank keeps the nibble, then an unknown pattern only flags err
        drive(1'b0, 1'b1, 8'hFF);
        push(1, 0, 4'h1, 4'hF, 0, 1, 1, 0, 2'b11, 8'd0, -1, -1);
        wait_cyc(40);
        drive(1'b0, 1'b1, 8'h55);
        push(0, 1, 4'h1, 4'hF, 0, 1, 1, 0, 2'b11, 8'd1, -1, -1);
        wait_cyc(40);

        // Recommit of an identical value is silent
        drive(1'b0, 1'b1, 8'hC0);
        push(1, 0, 4'h0, 4'hF, 0, 1, 0, 0, 2'b11, 8'd1, -1, -1);
        wait_cyc(40);
        drive(1'b1, 1'b1, 8'hC0);
        wait_cyc(3);
        drive(1'b0, 1'b1, 8'hC0);
        wait_cyc(40);
        check("recommit_hold", {16'h0, dig1_val, dig1_dp, dig1_blank, dig_vld}, {16'h0, 4'h0, 1'b0, 1'b0, 2'b11});

        // Error counter saturation
        for (int i = 1; i <= 300; i++) begin
            drive(1'b0, 1'b1, (i % 2 == 1) ? 8'h56 : 8'h55);
            push(0, 1, 4'h0, 4'hF, 0, 1, 0, 0, 2'b11, (i + 1 > 255) ? 8'd255 : 8'(i + 1), -1, -1);
            wait_cyc(22);
        end
        check("err_cnt_sat", {16'h0, err_cnt}, 24'h0000FF);

        // Reset in the middle of a settle window
        drive(1'b0, 1'b1, 8'hA4);
        wait_cyc(10);
        rst_n = 1'b0;
        #1;
        check("async_reset", act, 24'h0);
        drive(1'b1, 1'b1, 8'hFF);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(40);
        check("post_reset_idle", act, 24'h0);

        check("queue_drained", 24'(exp_q.size()), 24'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
